rx_ltssm: RTL and testbench

Receive-side LTSSM companion to the transmit-side LTSSM. It follows the state commanded by the main LTSSM and watches decoded ordered sets from the OS decoder: TS1, TS2 and IDLE. For each state it counts consecutive qualifying ordered sets, captures the link number on upstream ports, and enforces a state timeout. It reports completion to the main LTSSM with a one-cycle finish pulse plus an exit-state code. The main LTSSM advances only when both the TX and RX finish flags have been seen.

---
 rtl/rx_ltssm.sv | 261 ++++++++++++++++++++++++++
 tb/tb_rx_ltssm.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_ltssm.sv
// -----------------------------------------------------------------------------
// rx_ltssm
//
// Receive-side companion to the transmit-side LTSSM. It tracks the state the
// main LTSSM commands and watches decoded ordered sets (TS1, TS2, IDLE). For
// each training state it counts consecutive qualifying ordered sets, captures
// the link number on upstream ports, and enforces a state timeout. Completion
// is reported as a one-cycle finish pulse plus the exit-state code.
//
// Ports:
//   Pclk              clock
//   Reset             asynchronous, active-low reset
//   SetRXState[3:0]   state commanded by the main LTSSM (shared encoding)
//   RXFinishFlag      one-cycle pulse: exit criteria met (or timeout)
//   RXExitTo[3:0]     target state, valid with RXFinishFlag, held afterwards
//   OSValid           one-cycle strobe: one complete ordered set decoded
//   OSType[2:0]       TS1=000, TS2=001, IDLE=100, anything else is "other"
//   OSLinkNum[7:0]    link number field of the received TS
//   OSLaneNum[7:0]    lane number field of the received TS
//   ReadLinkNum[7:0]  link number currently held in the link register
//   WriteLinkNum[7:0] link number to store (upstream link capture)
//   WriteLinkNumFlag  one-cycle write strobe for WriteLinkNum
// -----------------------------------------------------------------------------
module rx_ltssm #(
  parameter int unsigned DEVICETYPE     = 0,
  parameter int unsigned LANESNUMBER    = 16,
  parameter logic [7:0]  PAD            = 8'hF7,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd6000000
) (
  input  logic       Pclk,
  input  logic       Reset,
  input  logic [3:0] SetRXState,
  output logic       RXFinishFlag,
  output logic [3:0] RXExitTo,
  input  logic       OSValid,
  input  logic [2:0] OSType,
  input  logic [7:0] OSLinkNum,
  input  logic [7:0] OSLaneNum,
  input  logic [7:0] ReadLinkNum,
  output logic [7:0] WriteLinkNum,
  output logic       WriteLinkNumFlag
);

  typedef enum logic [3:0] {
    DETECT_QUIET         = 4'd0,
    DETECT_ACTIVE        = 4'd1,
    POLLING_ACTIVE       = 4'd2,
    POLLING_CONFIG       = 4'd3,
    CFG_LINKWIDTH_START  = 4'd4,
    CFG_LINKWIDTH_ACCEPT = 4'd5,
    CFG_LANENUM_WAIT     = 4'd6,
    CFG_LANENUM_ACTIVE   = 4'd7,
    CFG_COMPLETE         = 4'd8,
    CFG_IDLE             = 4'd9,
    L0                   = 4'd10,
    IDLE                 = 4'd15
  } ltssm_state_e;

  localparam logic [2:0] OS_TS1  = 3'b000;
  localparam logic [2:0] OS_TS2  = 3'b001;
  localparam logic [2:0] OS_IDLE = 3'b100;

  localparam logic [7:0] CNT_LONG  = 8'd8;
  localparam logic [7:0] CNT_SHORT = 8'd2;

  localparam bit         UPSTREAM      = (DEVICETYPE == 1);
  localparam logic [23:0] TIMER_LAST   = TIMEOUT_CYCLES - 24'd1;

  // The decoder merges lanes before this block, so the lane count never sets
  // a datapath width here; this empty guard only documents that a zero-lane
  // configuration is not meaningful.
  if (LANESNUMBER < 1) begin : g_no_lanes
  end

  // Consecutive-set counter saturates instead of wrapping so a long run of
  // qualifying sets can never alias back to a small count.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  ltssm_state_e state_q, state_d;
  logic [7:0]   count_q, count_d;
  logic [23:0]  timer_q, timer_d;
  logic [7:0]   last_link_q, last_link_d;
  logic         done_q, done_d;
  logic         finish_q, finish_d;
  logic [3:0]   exit_to_q, exit_to_d;
  logic [7:0]   write_link_q, write_link_d;
  logic         write_flag_q, write_flag_d;

  // ---------------------------------------------------------------------------
  // Per-state qualification rules
  // ---------------------------------------------------------------------------
  logic         is_ts1, is_ts2, is_idle;
  logic         link_match, link_not_pad, lane_not_pad;
  logic         active;        // training state with counting and timer
  logic         qualifies;     // current ordered set counts toward exit
  logic         capture_link;  // upstream link-number capture state
  logic [7:0]   target;        // count that completes the state
  ltssm_state_e next_state;    // exit target on count completion

  assign is_ts1       = (OSType == OS_TS1);
  assign is_ts2       = (OSType == OS_TS2);
  assign is_idle      = (OSType == OS_IDLE);
  assign link_match   = (OSLinkNum == ReadLinkNum);
  assign link_not_pad = (OSLinkNum != PAD);
  assign lane_not_pad = (OSLaneNum != PAD);

  always_comb begin
    active       = 1'b1;
    qualifies    = 1'b0;
    capture_link = 1'b0;
    target       = CNT_LONG;
    next_state   = DETECT_QUIET;
    case (state_q)
      POLLING_ACTIVE: begin
        qualifies  = is_ts1 || is_ts2;
        next_state = POLLING_CONFIG;
      end
      POLLING_CONFIG: begin
        qualifies  = is_ts2;
        next_state = CFG_LINKWIDTH_START;
      end
      CFG_LINKWIDTH_START: begin
        // Downstream ports own the link number, so received sets must echo
        // it; upstream ports learn it from the partner instead.
        qualifies    = is_ts1 && link_not_pad && (UPSTREAM || link_match);
        capture_link = UPSTREAM;
        target       = CNT_SHORT;
        next_state   = CFG_LINKWIDTH_ACCEPT;
      end
      CFG_LINKWIDTH_ACCEPT: begin
        qualifies  = is_ts1 && link_match && lane_not_pad;
        target     = CNT_SHORT;
        next_state = CFG_LANENUM_WAIT;
      end
      CFG_LANENUM_WAIT: begin
        qualifies  = is_ts1 && link_match && lane_not_pad;
        target     = CNT_SHORT;
        next_state = CFG_LANENUM_ACTIVE;
      end
      CFG_LANENUM_ACTIVE: begin
        qualifies  = is_ts2 && link_match;
        target     = CNT_SHORT;
        next_state = CFG_COMPLETE;
      end
      CFG_COMPLETE: begin
        qualifies  = is_ts2 && link_match;
        next_state = CFG_IDLE;
      end
      CFG_IDLE: begin
        qualifies  = is_idle;
        next_state = L0;
      end
      // Detect, L0 and Idle: the TX side owns these, nothing to watch.
      default: active = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic state_change;
  logic count_done;

  assign state_change = (state_q != ltssm_state_e'(SetRXState));

  always_comb begin
    state_d      = ltssm_state_e'(SetRXState);
    count_d      = count_q;
    timer_d      = timer_q;
    last_link_d  = last_link_q;
    done_d       = done_q;
    finish_d     = 1'b0;
    exit_to_d    = exit_to_q;
    write_link_d = write_link_q;
    write_flag_d = 1'b0;
    count_done   = 1'b0;

    if (state_change) begin
      // A new commanded state restarts everything; a beat arriving in the
      // same cycle belongs to neither state and is dropped, and any finish
      // that would have fired is suppressed.
      count_d     = 8'd0;
      timer_d     = 24'd0;
      last_link_d = PAD;
      done_d      = 1'b0;
    end else if (active && !done_q) begin
      timer_d = timer_q + 24'd1;

      if (OSValid) begin
        if (qualifies) begin
          // Upstream: a change of advertised link number means the partner
          // has not settled yet, so consecutive counting starts over.
          if (capture_link && (OSLinkNum != last_link_q)) begin
            count_d = 8'd1;
          end else begin
            count_d = sat_inc8(count_q);
          end
          if (capture_link) begin
            last_link_d = OSLinkNum;
          end
          count_done = (count_d == target);
        end else begin
          count_d = 8'd0;
        end
      end

      // Count completion takes priority over a coincident timeout.
      if (count_done) begin
        finish_d  = 1'b1;
        exit_to_d = next_state;
        done_d    = 1'b1;
        if (capture_link) begin
          write_link_d = OSLinkNum;
          write_flag_d = 1'b1;
        end
      end else if (timer_q == TIMER_LAST) begin
        finish_d  = 1'b1;
        exit_to_d = DETECT_QUIET;
        done_d    = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Pclk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      count_q      <= 8'd0;
      timer_q      <= 24'd0;
      last_link_q  <= PAD;
      done_q       <= 1'b0;
      finish_q     <= 1'b0;
      exit_to_q    <= DETECT_QUIET;
      write_link_q <= 8'd0;
      write_flag_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      timer_q      <= timer_d;
      last_link_q  <= last_link_d;
      done_q       <= done_d;
      finish_q     <= finish_d;
      exit_to_q    <= exit_to_d;
      write_link_q <= write_link_d;
      write_flag_q <= write_flag_d;
    end
  end

  assign RXFinishFlag     = finish_q;
  assign RXExitTo         = exit_to_q;
  assign WriteLinkNum     = write_link_q;
  assign WriteLinkNumFlag = write_flag_q;

endmodule

// File: tb/tb_rx_ltssm.sv
// -----------------------------------------------------------------------------
// tb_rx_ltssm
//
// Bench for rx_ltssm (upstream configuration, short timeout). Expected finish
// events are pushed to a scoreboard as stimulus is driven and popped when the
// DUT pulses RXFinishFlag.
// -----------------------------------------------------------------------------
module tb_rx_ltssm;

  localparam logic [7:0] PAD = 8'hF7;
  localparam logic [2:0] TS1 = 3'b000;
  localparam logic [2:0] TS2 = 3'b001;
  localparam logic [2:0] OSI = 3'b100;

  logic       Pclk = 1'b0;
  logic       Reset;
  logic [3:0] SetRXState;
  logic       RXFinishFlag;
  logic [3:0] RXExitTo;
  logic       OSValid;
  logic [2:0] OSType;
  logic [7:0] OSLinkNum;
  logic [7:0] OSLaneNum;
  logic [7:0] ReadLinkNum;
  logic [7:0] WriteLinkNum;
  logic       WriteLinkNumFlag;

  always #5 Pclk = ~Pclk;

  rx_ltssm #(
    .DEVICETYPE    (1),
    .LANESNUMBER   (16),
    .PAD           (PAD),
    .TIMEOUT_CYCLES(24'd100)
  ) dut (
    .Pclk            (Pclk),
    .Reset           (Reset),
    .SetRXState      (SetRXState),
    .RXFinishFlag    (RXFinishFlag),
    .RXExitTo        (RXExitTo),
    .OSValid         (OSValid),
    .OSType          (OSType),
    .OSLinkNum       (OSLinkNum),
    .OSLaneNum       (OSLaneNum),
    .ReadLinkNum     (ReadLinkNum),
    .WriteLinkNum    (WriteLinkNum),
    .WriteLinkNumFlag(WriteLinkNumFlag)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [31:0] at;
    logic [3:0]  exit_to;
    logic        wflag;
    logic [7:0]  wlink;
  } exp_t;

  exp_t sb[$];
  logic [7:0] exp_wlink = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    if (obs !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, req);
    end
  endtask

  always @(posedge Pclk) cyc <= cyc + 1;

  // Every finish pulse must match the oldest outstanding expectation.
  always @(negedge Pclk) begin
    if (RXFinishFlag === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {31'd0, RXFinishFlag}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("finish_cycle", cyc, e.at);
        chk("exit_to", {28'd0, RXExitTo}, {28'd0, e.exit_to});
        chk("wlink_flag", {31'd0, WriteLinkNumFlag}, {31'd0, e.wflag});
        chk("wlink_num", {24'd0, WriteLinkNum}, {24'd0, e.wlink});
      end
    end else if (WriteLinkNumFlag !== 1'b0) begin
      chk("wflag_without_finish", {31'd0, WriteLinkNumFlag}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge Pclk);
    #1;
  endtask

  task automatic set_state(input logic [3:0] s);
    SetRXState = s;
    tick();
    tick();
  endtask

  task automatic send(input logic [2:0] t, input logic [7:0] ln, input logic [7:0] lane);
    OSValid   = 1'b1;
    OSType    = t;
    OSLinkNum = ln;
    OSLaneNum = lane;
    tick();
    OSValid   = 1'b0;
  endtask

  task automatic expect_finish(input logic [3:0] ex, input logic wf, input logic [7:0] wl,
                               input int at);
    exp_t e;
    e.at      = at;
    e.exit_to = ex;
    e.wflag   = wf;
    e.wlink   = wl;
    sb.push_back(e);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_flag"},  {31'd0, RXFinishFlag},     32'd0);
    chk({tag, "_exit"},  {28'd0, RXExitTo},         32'd0);
    chk({tag, "_wlink"}, {24'd0, WriteLinkNum},     32'd0);
    chk({tag, "_wflag"}, {31'd0, WriteLinkNumFlag}, 32'd0);
  endtask

  int k0;

  initial begin
    Reset       = 1'b0;
    SetRXState  = 4'd15;
    OSValid     = 1'b0;
    OSType      = TS1;
    OSLinkNum   = 8'd0;
    OSLaneNum   = 8'd0;
    ReadLinkNum = 8'd0;
    repeat (3) tick();
    chk_reset_outputs("rst");
    Reset = 1'b1;
    repeat (2) tick();

    // PollingActive: 7 TS1 + 1 TS2 -> PollingConfigration one cycle later
    set_state(4'd2);
    repeat (7) send(TS1, PAD, PAD);
    expect_finish(4'd3, 1'b0, exp_wlink, cyc + 1);
    send(TS2, PAD, PAD);
    repeat (4) tick();
    set_state(4'd15);

    // PollingConfigration: 5 TS2, 1 TS1 breaks the run, then 8 TS2
    set_state(4'd3);
    repeat (5) send(TS2, PAD, PAD);
    send(TS1, PAD, PAD);
    repeat (7) send(TS2, PAD, PAD);
    expect_finish(4'd4, 1'b0, exp_wlink, cyc + 1);
    send(TS2, PAD, PAD);
    repeat (4) tick();
    set_state(4'd15);

    // LinkWidthStart, upstream: link 3, 5, 5 -> capture 5
    set_state(4'd4);
    send(TS1, 8'd3, 8'd0);
    send(TS1, 8'd5, 8'd0);
    exp_wlink = 8'd5;
    expect_finish(4'd5, 1'b1, exp_wlink, cyc + 1);
    send(TS1, 8'd5, 8'd0);
    repeat (4) tick();
    set_state(4'd15);

    // LinkWidthStart: a PAD-link TS1 breaks the run and is not counted
    set_state(4'd4);
    send(TS1, 8'd7, 8'd0);
    send(TS1, PAD, 8'd0);
    send(TS1, 8'd7, 8'd0);
    exp_wlink = 8'd7;
    expect_finish(4'd5, 1'b1, exp_wlink, cyc + 1);
    send(TS1, 8'd7, 8'd0);
    repeat (4) tick();
    set_state(4'd15);

    // LinkWidthAccept: PAD lane is not counted, then two good TS1
    ReadLinkNum = 8'd7;
    set_state(4'd5);
    send(TS1, 8'd7, PAD);
    send(TS1, 8'd7, 8'd0);
    expect_finish(4'd6, 1'b0, exp_wlink, cyc + 1);
    send(TS1, 8'd7, 8'd1);
    repeat (4) tick();
    set_state(4'd15);

    // LaneNumActive: two TS2 with matching link
    set_state(4'd7);
    send(TS2, 8'd7, 8'd0);
    expect_finish(4'd8, 1'b0, exp_wlink, cyc + 1);
    send(TS2, 8'd7, 8'd0);
    repeat (4) tick();
    set_state(4'd15);

    // ConfigrationComplete with link mismatch: only the timeout fires
    ReadLinkNum = 8'd1;
    k0 = cyc;
    expect_finish(4'd0, 1'b0, exp_wlink, k0 + 101);
    set_state(4'd8);
    repeat (8) send(TS2, 8'd2, 8'd0);
    repeat (100) tick();
    set_state(4'd15);

    // ConfigrationIdle: 8 IDLE -> L0, then 8 more with no second pulse
    set_state(4'd9);
    repeat (7) send(OSI, 8'd0, 8'd0);
    expect_finish(4'd10, 1'b0, exp_wlink, cyc + 1);
    send(OSI, 8'd0, 8'd0);
    repeat (8) send(OSI, 8'd0, 8'd0);
    repeat (4) tick();
    set_state(4'd15);

    // L0: nothing is counted
    set_state(4'd10);
    repeat (10) send(OSI, 8'd0, 8'd0);
    repeat (4) tick();

    // Completing beat coincides with a state change: finish is suppressed
    set_state(4'd2);
    repeat (7) send(TS1, PAD, PAD);
    SetRXState = 4'd15;
    send(TS1, PAD, PAD);
    repeat (4) tick();
    chk("exit_hold", {28'd0, RXExitTo}, 32'd10);

    // Reset mid-count clears everything immediately and emits no pulse
    set_state(4'd2);
    repeat (4) send(TS1, PAD, PAD);
    Reset = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    repeat (2) tick();
    Reset = 1'b1;
    repeat (2) tick();
    repeat (4) send(TS1, PAD, PAD);
    repeat (4) tick();
    chk_reset_outputs("post_rst");

    repeat (4) tick();
    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
